// File: rtl/bus_master_if.sv
// Command/response port of bus_master: single-word read/write requests in,
// completion pulse and read data out.
interface bus_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [11:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        busy;

    // Controller side: issues commands and receives completions.
    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, busy
    );

    // bus_master side: accepts commands and reports completions.
    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/bus_master.sv
// Initiator for the MCU-style parallel bus (12-bit ADDR, 16-bit DATA,
// active-low RD/WR). Each accepted command becomes one bus cycle of
// SETUP_CYC address setup, STROBE_CYC strobe and HOLD_CYC hold cycles.
// All bus pins come straight from registers, so RD/WR cannot glitch.
module bus_master #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic        clk,
    input  logic        rst,
    bus_master_if.slave cmd,
    output logic [11:0] ADDR,
    output logic        RD,
    output logic        WR,
    inout  wire  [15:0] DATA
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    // Counter reload values: each phase runs until the counter hits zero.
    localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
    localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic        lat_wr;
    logic [15:0] lat_wdata;
    logic        drive;
    logic        rsp_valid_q;
    logic [15:0] rsp_rdata_q;

    assign cmd.cmd_ready = (state == IDLE);
    assign cmd.busy      = (state != IDLE);
    assign cmd.rsp_valid = rsp_valid_q;
    assign cmd.rsp_rdata = rsp_rdata_q;

    // Write data owns the bus from the first SETUP cycle to the last HOLD cycle.
    assign DATA = drive ? lat_wdata : 'z;

    // Bus-cycle sequencer: phase state, shared down-counter and registered pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            lat_wr      <= 1'b0;
            lat_wdata   <= '0;
            drive       <= 1'b0;
            ADDR        <= '0;
            RD          <= 1'b1;
            WR          <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        ADDR      <= cmd.cmd_addr;
                        lat_wr    <= cmd.cmd_wr;
                        lat_wdata <= cmd.cmd_wdata;
                        drive     <= cmd.cmd_wr;
                        cnt       <= SETUP_LD;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == 8'd0) begin
                        cnt   <= STROBE_LD;
                        state <= STROBE;
                        RD    <= lat_wr;
                        WR    <= ~lat_wr;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                STROBE: begin
                    if (cnt == 8'd0) begin
                        cnt   <= HOLD_LD;
                        state <= HOLD;
                        RD    <= 1'b1;
                        WR    <= 1'b1;
                        if (!lat_wr) begin
                            rsp_rdata_q <= DATA;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 8'd0) begin
                        state       <= IDLE;
                        drive       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master.sv
// Bench for bus_master: one instance with default timing, one with
// SETUP=3/STROBE=4/HOLD=2. A behavioural model predicts every bus pin from
// the cycle offset since acceptance; a scoreboard checks completions.
module tb_bus_master;

    localparam int S1 = 3;
    localparam int T1 = 4;
    localparam int H1 = 2;

    typedef struct packed {
        logic        wr;
        logic [15:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    bus_master_if ifc0 ();
    bus_master_if ifc1 ();

    logic [11:0] addr0, addr1;
    logic        rd0, wr0, rd1, wr1;
    wire  [15:0] bus0, bus1;

    bus_master u_dut0 (
        .clk  (clk),
        .rst  (rst),
        .cmd  (ifc0.slave),
        .ADDR (addr0),
        .RD   (rd0),
        .WR   (wr0),
        .DATA (bus0)
    );

    bus_master #(
        .SETUP_CYC  (S1),
        .STROBE_CYC (T1),
        .HOLD_CYC   (H1)
    ) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .cmd  (ifc1.slave),
        .ADDR (addr1),
        .RD   (rd1),
        .WR   (wr1),
        .DATA (bus1)
    );

    // Stimulus side, indexed by instance.
    logic        cv [2];
    logic        cw [2];
    logic [11:0] ca [2];
    logic [15:0] cd [2];

    assign ifc0.cmd_valid = cv[0];
    assign ifc0.cmd_wr    = cw[0];
    assign ifc0.cmd_addr  = ca[0];
    assign ifc0.cmd_wdata = cd[0];
    assign ifc1.cmd_valid = cv[1];
    assign ifc1.cmd_wr    = cw[1];
    assign ifc1.cmd_addr  = ca[1];
    assign ifc1.cmd_wdata = cd[1];

    // Observed side, indexed by instance.
    logic        rdy_s  [2];
    logic        rspv_s [2];
    logic        busy_s [2];
    logic        rd_s   [2];
    logic        wr_s   [2];
    logic [15:0] rspd_s [2];
    logic [15:0] data_s [2];
    logic [11:0] addr_s [2];

    assign rdy_s[0]  = ifc0.cmd_ready;
    assign rdy_s[1]  = ifc1.cmd_ready;
    assign rspv_s[0] = ifc0.rsp_valid;
    assign rspv_s[1] = ifc1.rsp_valid;
    assign busy_s[0] = ifc0.busy;
    assign busy_s[1] = ifc1.busy;
    assign rspd_s[0] = ifc0.rsp_rdata;
    assign rspd_s[1] = ifc1.rsp_rdata;
    assign rd_s[0]   = rd0;
    assign rd_s[1]   = rd1;
    assign wr_s[0]   = wr0;
    assign wr_s[1]   = wr1;
    assign addr_s[0] = addr0;
    assign addr_s[1] = addr1;
    assign data_s[0] = bus0;
    assign data_s[1] = bus1;

    // Peripheral: power-up content from pf(), overwritten by bus writes.
    function automatic logic [15:0] pf(input logic [11:0] a);
        logic [15:0] x;
        x = {4'h0, a ^ 12'h010};
        return (x * 16'h9E37) ^ 16'h00A5;
    endfunction

    logic [15:0] pmem [2][4096];
    bit          pwr  [2][4096];
    logic        keep [2];
    logic [15:0] pv0, pv1;

    assign pv0 = pwr[0][addr0] ? pmem[0][addr0] : pf(addr0);
    assign pv1 = pwr[1][addr1] ? pmem[1][addr1] : pf(addr1);

    // Peripheral answers reads; otherwise the bench holds 0000 on the bus
    // whenever the master is expected to have released it.
    assign bus0 = (rd0 == 1'b0) ? pv0 : (keep[0] ? 16'h0000 : 16'hzzzz);
    assign bus1 = (rd1 == 1'b0) ? pv1 : (keep[1] ? 16'h0000 : 16'hzzzz);

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (wr_s[i] == 1'b0) begin
                pmem[i][addr_s[i]] <= data_s[i];
                pwr[i][addr_s[i]]  <= 1'b1;
            end
        end
    end

    // Reference model state.
    int          ps [2];
    int          pt [2];
    int          ph [2];
    int          k  [2];
    logic        mw [2];
    logic [11:0] mad [2];
    logic [15:0] mwd [2];
    logic        rspf [2];
    logic [15:0] last_rd [2];
    logic [15:0] shadow [int];
    exp_t        sbq0 [$];
    exp_t        sbq1 [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int i, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d @%0t: got %h want %h", nm, i, $time, act, exp);
        end
    endtask

    // Monitor: advance the model at each edge, compare pins 2 ns later,
    // and pop the scoreboard whenever a completion is presented.
    initial begin : monitor
        ps[0] = 1;  pt[0] = 2;  ph[0] = 1;
        ps[1] = S1; pt[1] = T1; ph[1] = H1;
        for (int i = 0; i < 2; i++) begin
            k[i] = 0; mw[i] = 1'b0; mad[i] = '0; mwd[i] = '0;
            rspf[i] = 1'b0; keep[i] = 1'b1;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                int len;
                len = ps[i] + pt[i] + ph[i];
                if (rst) begin
                    k[i] = 0; rspf[i] = 1'b0; mad[i] = '0; mw[i] = 1'b0;
                end else begin
                    rspf[i] = (k[i] == len);
                    if (k[i] == 0) begin
                        if (cv[i]) begin
                            k[i] = 1; mw[i] = cw[i]; mad[i] = ca[i]; mwd[i] = cd[i];
                        end
                    end else if (k[i] == len) begin
                        k[i] = 0;
                    end else begin
                        k[i]++;
                    end
                end
                keep[i] = !(k[i] != 0 && mw[i]);
            end
            #2;
            for (int i = 0; i < 2; i++) begin
                logic strobe;
                logic exp_rd;
                exp_t e;
                strobe = (k[i] >= ps[i] + 1) && (k[i] <= ps[i] + pt[i]);
                exp_rd = !(strobe && !mw[i]);
                chk("cmd_ready", i, 16'(rdy_s[i]), 16'(k[i] == 0));
                chk("busy", i, 16'(busy_s[i]), 16'(k[i] != 0));
                chk("rsp_valid", i, 16'(rspv_s[i]), 16'(rspf[i]));
                chk("ADDR", i, 16'(addr_s[i]), 16'(mad[i]));
                chk("RD", i, 16'(rd_s[i]), 16'(exp_rd));
                chk("WR", i, 16'(wr_s[i]), 16'(!(strobe && mw[i])));
                if (k[i] != 0 && mw[i])
                    chk("DATA_drive", i, data_s[i], mwd[i]);
                else if (exp_rd)
                    chk("DATA_release", i, data_s[i], 16'h0000);
                if (rspv_s[i]) begin
                    if ((i == 0 ? sbq0.size() : sbq1.size()) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected inst%0d @%0t: got rsp_valid=1 want no response",
                                 i, $time);
                    end else begin
                        e = (i == 0) ? sbq0.pop_front() : sbq1.pop_front();
                        chk(e.wr ? "rsp_rdata_after_write" : "rsp_rdata_read", i,
                            rspd_s[i], e.rdata);
                    end
                end
            end
        end
    end

    // Issue one command from a negedge; returns on a negedge. hold_extra keeps
    // cmd_valid high with scrambled fields for that many cycles after acceptance.
    task automatic issue(input int i, input logic wr, input logic [11:0] a,
                         input logic [15:0] d, input bit push, input int hold_extra);
        int n;
        cv[i] = 1'b1; cw[i] = wr; ca[i] = a; cd[i] = d;
        n = 0;
        while (!rdy_s[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_s[i]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout inst%0d @%0t: got cmd_ready=0 want 1 within 200 cycles",
                     i, $time);
            cv[i] = 1'b0;
            return;
        end
        @(posedge clk);
        if (push) begin
            exp_t e;
            int   key;
            key  = i * 4096 + int'(a);
            e.wr = wr;
            if (wr) begin
                e.rdata     = last_rd[i];
                shadow[key] = d;
            end else begin
                e.rdata    = shadow.exists(key) ? shadow[key] : pf(a);
                last_rd[i] = e.rdata;
            end
            if (i == 0) sbq0.push_back(e);
            else        sbq1.push_back(e);
        end
        repeat (hold_extra) begin
            @(negedge clk);
            ca[i] = 12'($urandom);
            cd[i] = 16'($urandom);
            cw[i] = 1'($urandom);
        end
        @(negedge clk);
        cv[i] = 1'b0;
    endtask

    initial begin : stim
        int n;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cv[i] = 1'b0; cw[i] = 1'b0; ca[i] = '0; cd[i] = '0; last_rd[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_rsp_rdata", 0, rspd_s[0], 16'h0000);
        chk("rst_rsp_rdata", 1, rspd_s[1], 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        // Basic write and read with default timing.
        issue(0, 1'b1, 12'h123, 16'hBEEF, 1'b1, 0);
        repeat (5) @(negedge clk);
        issue(0, 1'b0, 12'h010, 16'h0000, 1'b1, 0);
        repeat (5) @(negedge clk);

        // Back-to-back: second command presented in the completion cycle.
        issue(0, 1'b1, 12'h001, 16'h5A5A, 1'b1, 0);
        issue(0, 1'b0, 12'h002, 16'h0000, 1'b1, 0);
        repeat (6) @(negedge clk);

        // cmd_valid held high with changing fields while busy.
        issue(0, 1'b0, 12'h0AB, 16'h0000, 1'b1, 3);
        repeat (6) @(negedge clk);

        // Reset during the first STROBE cycle of a write.
        issue(0, 1'b1, 12'hFFF, 16'h1234, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        issue(0, 1'b0, 12'h123, 16'h0000, 1'b1, 0);
        repeat (5) @(negedge clk);

        // Slow instance: read, write, read back.
        issue(1, 1'b0, 12'h055, 16'h0000, 1'b1, 0);
        issue(1, 1'b1, 12'h055, 16'hC0DE, 1'b1, 0);
        issue(1, 1'b0, 12'h055, 16'h0000, 1'b1, 0);

        // Randomized traffic on a small address window so reads revisit writes.
        for (int j = 0; j < 40; j++) begin
            issue(0, 1'($urandom), 12'($urandom_range(0, 15)),
                  16'($urandom_range(1, 65535)), 1'b1, 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        for (int j = 0; j < 12; j++) begin
            issue(1, 1'($urandom), 12'($urandom_range(0, 15)),
                  16'($urandom_range(1, 65535)), 1'b1, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        n = 0;
        while ((sbq0.size() != 0 || sbq1.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("sb_drain", 0, 16'(sbq0.size()), 16'h0000);
        chk("sb_drain", 1, 16'(sbq1.size()), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
